multicycle_ctrl: RTL and testbench

- Main control FSM of the multi-cycle MIPS-subset core. It sits directly upstream of the ALU control decoder.
- Sequences fetch/decode/execute/memory/writeback per instruction from the IR opcode.
- Drives the 2-bit alu_ct_op consumed by the ALU control decoder, plus all datapath mux, register-file and memory strobes.
- Handles a memory ready handshake with a bounded wait timeout.

---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle core control path.
// Opcodes, ALU op codes and mux selects used by the control FSM and ALU decoder.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter; flags a timeout on the last allowed wait cycle.
// Restarts itself after firing so a stuck fetch retries with a fresh budget.
module mem_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt;

    assign timeout = waiting && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst || clear || timeout) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset core.
// Moore outputs per state, with mem_ready-qualified fetch strobes and timeout.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ct_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
);

    state_t state;
    state_t next;
    logic   waiting;
    logic   clear;
    logic   timeout;
    logic   unused_zero;

    // The branch decision is taken in the datapath via pc_write_cond.
    assign unused_zero = zero;

    assign waiting = rst && !mem_ready &&
                     (state == S_FETCH || state == S_MEM_RD ||
                      state == S_MEM_WR);
    assign clear = mem_ready || (next != state);

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT),
        .WAIT_W  (WAIT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .waiting(waiting),
        .timeout(timeout)
    );

    always_comb begin
        next          = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RT;
        alu_ct_op     = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    next      = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = ALUB_IMM_SH;
                    case (opcode)
                        OP_RTYPE:     next = S_RTYPE_EX;
                        OP_LW, OP_SW: next = S_MEM_ADR;
                        OP_BEQ:       next = S_BRANCH;
                        OP_ADDIU:     next = S_ADDI_EX;
                        OP_J:         next = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    next      = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    next     = mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    next       = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_ct_op = ALUOP_FUNCT;
                    next      = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    next      = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ct_op     = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                default: next = S_FETCH;
            endcase
            // Abandon the access: report it and restart from fetch.
            if (timeout) begin
                bus_err    = 1'b1;
                instr_done = 1'b1;
                ir_write   = 1'b0;
                pc_write   = 1'b0;
                reg_write  = 1'b0;
                next       = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= next;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with MAX_WAIT=4.
// Output bundle: {pw,pwc,ps,iod,mr,mw,irw,m2r,rw,rd,a,b,op,done,ill,bus}.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic       instr_done, illegal_op, bus_err;
    logic [1:0] pc_source, alu_src_b, alu_ct_op;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MAX_WAIT(4),
        .WAIT_W  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ct_op    (alu_ct_op),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .bus_err      (bus_err)
    );

    localparam logic [19:0] E_ZERO    = 20'h00000;
    localparam logic [19:0] E_FETCH_R = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH_W = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH_T = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00,
                                         1'b1, 1'b0, 1'b1};
    localparam logic [19:0] E_DECODE  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_DEC_ILL = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00,
                                         1'b1, 1'b1, 1'b0};
    localparam logic [19:0] E_MEM_ADR = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_MEM_RD  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_MEM_RDT = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b1};
    localparam logic [19:0] E_MEM_WB  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_MEM_WRW = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_MEM_WRR = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_RT_EX   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_RT_WB   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_ADDI_EX = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00,
                                         1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_ADDI_WB = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_BRANCH  = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01,
                                         1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_JUMP    = {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                         1'b1, 1'b0, 1'b0};

    logic [19:0] obs;
    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
                  alu_src_a, alu_src_b, alu_ct_op, instr_done, illegal_op,
                  bus_err};

    task automatic check(input string tag, input logic [19:0] got,
                         input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set just after a rising edge; outputs sampled mid-cycle.
    task automatic cyc(input string tag, input logic [19:0] exp);
        #4;
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_hold", E_ZERO);
        rst = 1'b1;

        // R-type addu
        cyc("rt_fetch", E_FETCH_R);
        cyc("rt_decode", E_DECODE);
        cyc("rt_ex", E_RT_EX);
        cyc("rt_wb", E_RT_WB);

        // lw with three wait cycles in MEM_RD
        opcode = 6'b100011;
        cyc("lw_fetch", E_FETCH_R);
        cyc("lw_decode", E_DECODE);
        cyc("lw_adr", E_MEM_ADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MEM_RD);
        mem_ready = 1'b1;
        cyc("lw_rd_done", E_MEM_RD);
        cyc("lw_wb", E_MEM_WB);

        // beq taken and not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        cyc("beq1_fetch", E_FETCH_R);
        cyc("beq1_decode", E_DECODE);
        cyc("beq1_branch", E_BRANCH);
        zero = 1'b0;
        cyc("beq0_fetch", E_FETCH_R);
        cyc("beq0_decode", E_DECODE);
        cyc("beq0_branch", E_BRANCH);

        // addiu and j
        opcode = 6'b001001;
        cyc("addi_fetch", E_FETCH_R);
        cyc("addi_decode", E_DECODE);
        cyc("addi_ex", E_ADDI_EX);
        cyc("addi_wb", E_ADDI_WB);
        opcode = 6'b000010;
        cyc("j_fetch", E_FETCH_R);
        cyc("j_decode", E_DECODE);
        cyc("j_jump", E_JUMP);

        // illegal opcode
        opcode = 6'b111111;
        cyc("ill_fetch", E_FETCH_R);
        cyc("ill_decode", E_DEC_ILL);

        // fetch timeout twice, then completion on the 4th cycle
        mem_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) cyc("fto_wait", E_FETCH_W);
            cyc("fto_err", E_FETCH_T);
        end
        for (int i = 0; i < 3; i++) cyc("fok_wait", E_FETCH_W);
        mem_ready = 1'b1;
        opcode    = 6'b101011;
        cyc("fok_edge", E_FETCH_R);

        // sw with one wait cycle
        cyc("sw_decode", E_DECODE);
        cyc("sw_adr", E_MEM_ADR);
        mem_ready = 1'b0;
        cyc("sw_wait", E_MEM_WRW);
        mem_ready = 1'b1;
        cyc("sw_done", E_MEM_WRR);

        // lw timing out in MEM_RD
        opcode = 6'b100011;
        cyc("lwto_fetch", E_FETCH_R);
        cyc("lwto_decode", E_DECODE);
        cyc("lwto_adr", E_MEM_ADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lwto_wait", E_MEM_RD);
        cyc("lwto_err", E_MEM_RDT);
        mem_ready = 1'b1;
        cyc("lwto_refetch", E_FETCH_R);

        // reset during MEM_WR
        opcode = 6'b101011;
        cyc("swr_decode", E_DECODE);
        cyc("swr_adr", E_MEM_ADR);
        mem_ready = 1'b0;
        cyc("swr_wait", E_MEM_WRW);
        rst = 1'b0;
        cyc("swr_rst0", E_ZERO);
        mem_ready = 1'b1;
        cyc("swr_rst1", E_ZERO);
        rst       = 1'b1;
        mem_ready = 1'b0;
        cyc("swr_fetch_w", E_FETCH_W);
        mem_ready = 1'b1;
        cyc("swr_fetch_r", E_FETCH_R);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
